// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, defaults and MEM/WB types for the memory stage
package mem_stage_pkg;

    localparam int DATA_W           = 8;
    localparam int REG_ADDR_W       = 5;
    localparam int PC_SIZE_DEF      = 10;
    localparam int DMEM_DEPTH_DEF   = 256;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Non-memory half of the MEM/WB pipeline register
    typedef struct packed {
        data_t     alu_result;
        logic      mem_to_reg;
        logic      reg_write;
        reg_addr_t write_register;
    } mem_wb_t;

    // Write-back source select shared by the register file and EXE forwarding
    function automatic data_t wb_select(input logic mem_to_reg, input data_t mem_data,
                                        input data_t alu_data);
        return mem_to_reg ? mem_data : alu_data;
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// rtl/mem_stage_data_mem.sv - byte-wide data memory with sync write, registered read and debug read
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  data_t         wr_data,
    output data_t         rd_data,
    input  logic [AW-1:0] dbg_addr,
    output data_t         dbg_data
);

    // Contents survive reset; only the read register is cleared
    data_t mem [0:DEPTH-1];

    // Write port: reset blocks any store issued in the same cycle
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[addr] <= wr_data;
        end
    end

    // Registered read port: returns 0 whenever no clean load is issued
    always_ff @(posedge clock) begin
        if (reset || !rd_en) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[addr];
        end
    end

    // Debug port sees the array as it stands, so a store shows up only after its edge
    always_comb begin
        dbg_data = mem[dbg_addr];
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: branch resolve, data memory access and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int PC_SIZE    = PC_SIZE_DEF,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PC_SIZE-1:0] PC_jump,
    input  logic               zero,
    input  logic [7:0]         ALU_result,
    input  logic [7:0]         write_data,
    input  logic               branch_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               mem_to_reg_in,
    input  logic               reg_write_in,
    input  logic [4:0]         write_register_in,
    input  logic [7:0]         dbg_addr,
    output logic               PC_src,
    output logic [PC_SIZE-1:0] PC_branch,
    output logic [7:0]         read_data,
    output logic [7:0]         alu_result_out,
    output logic               mem_to_reg_out,
    output logic               reg_write_out,
    output logic [4:0]         write_register_out,
    output logic [7:0]         wb_write_data,
    output logic               mem_conflict,
    output logic [7:0]         dbg_data
);

    localparam int AW = $clog2(DMEM_DEPTH);

    logic    [AW-1:0] mem_addr;
    logic             both_rw;
    logic             do_store;
    logic             do_load;
    mem_wb_t          mem_wb_q;

    // Address wraps modulo depth; simultaneous read+write cancels both accesses
    always_comb begin
        mem_addr = ALU_result[AW-1:0];
        both_rw  = mem_read_in & mem_write_in;
        do_store = mem_write_in & ~mem_read_in & ~reset;
        do_load  = mem_read_in & ~mem_write_in;
    end

    data_mem #(
        .DEPTH (DMEM_DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (do_store),
        .rd_en    (do_load),
        .addr     (mem_addr),
        .wr_data  (write_data),
        .rd_data  (read_data),
        .dbg_addr (dbg_addr[AW-1:0]),
        .dbg_data (dbg_data)
    );

    // Branch resolution goes straight back to IF with no register in the path
    always_comb begin
        PC_src    = branch_in & zero;
        PC_branch = PC_jump;
    end

    // MEM/WB pass-through fields load every cycle, no enable
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q.alu_result     <= ALU_result;
            mem_wb_q.mem_to_reg     <= mem_to_reg_in;
            mem_wb_q.reg_write      <= reg_write_in;
            mem_wb_q.write_register <= write_register_in;
        end
    end

    // Conflict flag is a one-cycle pulse following the offending cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_conflict <= 1'b0;
        end else begin
            mem_conflict <= both_rw;
        end
    end

    // Unpack MEM/WB register and pick the write-back value
    always_comb begin
        alu_result_out     = mem_wb_q.alu_result;
        mem_to_reg_out     = mem_wb_q.mem_to_reg;
        reg_write_out      = mem_wb_q.reg_write;
        write_register_out = mem_wb_q.write_register;
        wb_write_data      = wb_select(mem_wb_q.mem_to_reg, read_data, mem_wb_q.alu_result);
    end

endmodule
